// File: rtl/led_mmio_ctrl_pkg.sv
// Shared definitions for the LED MMIO peripheral.
//   - register byte offsets and the register index taken from addr[3:2]
//   - MODE encodings and CTRL bit positions
//   - apply_wstrb(): byte-lane merge used for all strobed stores
package led_mmio_ctrl_pkg;

  localparam int LED_CTRL_OFS   = 0;
  localparam int LED_PERIOD_OFS = 4;
  localparam int LED_DUTY_OFS   = 8;
  localparam int LED_STATUS_OFS = 12;

  // Word index within the 16-byte window (byte offset / 4)
  typedef enum logic [1:0] {
    REG_CTRL   = 2'(LED_CTRL_OFS / 4),
    REG_PERIOD = 2'(LED_PERIOD_OFS / 4),
    REG_DUTY   = 2'(LED_DUTY_OFS / 4),
    REG_STATUS = 2'(LED_STATUS_OFS / 4)
  } reg_idx_e;

  localparam logic [1:0] LED_MODE_STATIC = 2'b00;
  localparam logic [1:0] LED_MODE_BLINK  = 2'b01;
  localparam logic [1:0] LED_MODE_PWM    = 2'b10;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_MODE_LSB  = 1;
  localparam int CTRL_LEVEL_BIT = 3;

  // Replace the bytes of old_w selected by strb with those of new_w
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/led_pattern_gen.sv
// Blink / PWM pattern source for the LED peripheral.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   en, mode  CTRL.EN and CTRL.MODE as currently held in the register file
//   period    blink half-period in cycles (0 freezes the blink state)
//   duty      PWM on-count out of 256
//   clr       clears the blink counter (issued on a PERIOD store)
//   pattern   blink_state in blink mode, pwm_on in PWM mode, else 0
module led_pattern_gen
  import led_mmio_ctrl_pkg::*;
#(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic [7:0]          duty,
  input  logic                clr,
  output logic                pattern
);

  logic [PERIOD_W-1:0] bcnt_q, bcnt_d;
  logic [7:0]          pcnt_q, pcnt_d;
  logic                blink_state_q, blink_state_d;
  logic [1:0]          mode_prev_q, mode_prev_d;

  always_comb begin
    bcnt_d        = bcnt_q;
    pcnt_d        = pcnt_q;
    blink_state_d = blink_state_q;
    mode_prev_d   = mode;

    // Disabling or switching mode restarts the pattern from a clean state
    if (!en || (mode != mode_prev_q)) begin
      bcnt_d        = '0;
      pcnt_d        = '0;
      blink_state_d = 1'b0;
    end else begin
      case (mode)
        LED_MODE_BLINK: begin
          if (period == '0) begin
            bcnt_d = '0;
          end else if (bcnt_q >= period - PERIOD_W'(1)) begin
            // >= also recovers if PERIOD is shrunk below the running count
            bcnt_d        = '0;
            blink_state_d = ~blink_state_q;
          end else begin
            bcnt_d = bcnt_q + PERIOD_W'(1);
          end
        end
        LED_MODE_PWM: begin
          pcnt_d = pcnt_q + 8'd1;
        end
        default: begin
          bcnt_d = '0;
          pcnt_d = '0;
        end
      endcase
    end

    if (clr) bcnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q        <= '0;
      pcnt_q        <= '0;
      blink_state_q <= 1'b0;
      mode_prev_q   <= '0;
    end else begin
      bcnt_q        <= bcnt_d;
      pcnt_q        <= pcnt_d;
      blink_state_q <= blink_state_d;
      mode_prev_q   <= mode_prev_d;
    end
  end

  always_comb begin
    pattern = 1'b0;
    if (mode == LED_MODE_BLINK)    pattern = blink_state_q;
    else if (mode == LED_MODE_PWM) pattern = (pcnt_q < duty);
  end

endmodule

// File: rtl/led_mmio_ctrl.sv
// Memory-mapped LED peripheral on the CPU data-memory bus.
// Decodes a 16-byte window at BASE_ADDR holding CTRL, PERIOD, DUTY and STATUS,
// and drives a registered LED pin in static, blink or PWM mode.
// Ports:
//   sysclk, rst    clock and asynchronous active-high reset
//   addr           byte address; addr[3:2] selects the register
//   wdata, wstrb   store data and byte enables
//   wen, ren       single-cycle store / load requests
//   rdata, rvalid  registered load data and its one-cycle qualifier
//   led            registered LED drive
module led_mmio_ctrl
  import led_mmio_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 12'hFF0,
  parameter int                    PERIOD_W   = 24
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wen,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  led
);

  logic [3:0]          ctrl_q, ctrl_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [7:0]          duty_q, duty_d;
  logic [15:0]         toggles_q, toggles_d;
  logic                led_q, led_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;

  logic        sel, wr, rd;
  reg_idx_e    ridx;
  logic [31:0] rd_word, wr_word;
  logic        period_clr, status_clr;
  logic        en, level;
  logic [1:0]  mode;
  logic        pattern;
  logic        unused_ok;

  assign sel   = (addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  assign wr    = wen & sel;
  assign rd    = ren & sel;
  assign ridx  = reg_idx_e'(addr[3:2]);
  assign en    = ctrl_q[CTRL_EN_BIT];
  assign mode  = ctrl_q[CTRL_MODE_LSB +: 2];
  assign level = ctrl_q[CTRL_LEVEL_BIT];

  assign unused_ok = ^{addr[1:0], wr_word};

  led_pattern_gen #(
    .PERIOD_W(PERIOD_W)
  ) u_pattern_gen (
    .clk    (sysclk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .period (period_q),
    .duty   (duty_q),
    .clr    (period_clr),
    .pattern(pattern)
  );

  always_comb begin
    // Current register contents; also the merge base for strobed stores,
    // which is why a same-cycle load returns the pre-write value.
    rd_word = '0;
    case (ridx)
      REG_CTRL:   rd_word = {28'd0, ctrl_q};
      REG_PERIOD: rd_word = 32'(period_q);
      REG_DUTY:   rd_word = {24'd0, duty_q};
      REG_STATUS: rd_word = {15'd0, led_q, toggles_q};
      default:    rd_word = '0;
    endcase
    wr_word = apply_wstrb(rd_word, wdata, wstrb);

    ctrl_d     = ctrl_q;
    period_d   = period_q;
    duty_d     = duty_q;
    period_clr = 1'b0;
    status_clr = 1'b0;
    if (wr) begin
      case (ridx)
        REG_CTRL:   ctrl_d = wr_word[3:0];
        REG_PERIOD: begin
          period_d   = wr_word[PERIOD_W-1:0];
          period_clr = 1'b1;
        end
        REG_DUTY:   duty_d = wr_word[7:0];
        REG_STATUS: status_clr = 1'b1;
        default:    ;
      endcase
    end

    led_d = en & ((mode == LED_MODE_STATIC) ? level : pattern);

    toggles_d = toggles_q;
    if (led_d && !led_q && (toggles_q != 16'hFFFF)) toggles_d = toggles_q + 16'd1;
    if (status_clr) toggles_d = '0;

    rvalid_d = rd;
    rdata_d  = rd ? rd_word : rdata_q;
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      period_q  <= '0;
      duty_q    <= '0;
      toggles_q <= '0;
      led_q     <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      toggles_q <= toggles_d;
      led_q     <= led_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign led    = led_q;

endmodule

// File: tb/tb_led_mmio_ctrl.sv
// Directed bench for led_mmio_ctrl: reset, static, blink, PWM, bus corners
// and asynchronous reset, with hand-computed expectations.
module tb_led_mmio_ctrl;

  localparam logic [11:0] BASE       = 12'hFF0;
  localparam logic [11:0] A_CTRL     = BASE + 12'h0;
  localparam logic [11:0] A_PERIOD   = BASE + 12'h4;
  localparam logic [11:0] A_DUTY     = BASE + 12'h8;
  localparam logic [11:0] A_STATUS   = BASE + 12'hC;

  logic        sysclk = 1'b0;
  logic        rst;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wen, ren;
  logic [31:0] rdata;
  logic        rvalid;
  logic        led;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 sysclk = ~sysclk;

  led_mmio_ctrl #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(32),
    .BASE_ADDR (12'hFF0),
    .PERIOD_W  (24)
  ) dut (
    .sysclk(sysclk),
    .rst   (rst),
    .addr  (addr),
    .wdata (wdata),
    .wstrb (wstrb),
    .wen   (wen),
    .ren   (ren),
    .rdata (rdata),
    .rvalid(rvalid),
    .led   (led)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Drive at a falling edge, so each store/load covers exactly one rising edge
  task automatic bus_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge sysclk);
    addr = a; wdata = d; wstrb = s; wen = 1'b1;
    @(negedge sysclk);
    wen = 1'b0; wstrb = 4'h0;
  endtask

  task automatic bus_rd(input logic [11:0] a, input string tag, output logic [31:0] d);
    @(negedge sysclk);
    addr = a; ren = 1'b1;
    @(negedge sysclk);
    ren = 1'b0;
    check({tag, " rvalid"}, {31'd0, rvalid}, 32'd1);
    d = rdata;
  endtask

  task automatic rd_chk(input logic [11:0] a, input string tag, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, tag, d);
    check(tag, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int cnt;
    logic prev;
    int k;

    rst = 1'b1; addr = '0; wdata = '0; wstrb = '0; wen = 1'b0; ren = 1'b0;

    // 1. Reset
    repeat (2) @(negedge sysclk);
    check("reset led",    {31'd0, led},    32'd0);
    check("reset rvalid", {31'd0, rvalid}, 32'd0);
    check("reset rdata",  rdata,           32'd0);
    rst = 1'b0;
    rd_chk(A_CTRL,   "reset CTRL",   32'h0);
    rd_chk(A_PERIOD, "reset PERIOD", 32'h0);
    rd_chk(A_DUTY,   "reset DUTY",   32'h0);
    rd_chk(A_STATUS, "reset STATUS", 32'h0);
    @(negedge sysclk);
    check("rvalid one-cycle pulse", {31'd0, rvalid}, 32'd0);

    // 2. Static mode
    bus_wr(A_CTRL, 32'h9, 4'hF);
    check("static led lag", {31'd0, led}, 32'd0);
    @(negedge sysclk);
    check("static led on", {31'd0, led}, 32'd1);
    bus_wr(A_CTRL, 32'h1, 4'hF);
    check("static led hold", {31'd0, led}, 32'd1);
    @(negedge sysclk);
    check("static led off", {31'd0, led}, 32'd0);
    rd_chk(A_STATUS, "static STATUS", 32'h0000_0001);

    // 3. Blink, PERIOD=3
    bus_wr(A_PERIOD, 32'd3, 4'hF);
    bus_wr(A_CTRL, 32'h3, 4'hF);
    repeat (4) @(negedge sysclk);
    check("blink edge4 led", {31'd0, led}, 32'd0);
    @(negedge sysclk);
    check("blink edge5 led", {31'd0, led}, 32'd1);
    repeat (2) @(negedge sysclk);
    check("blink edge7 led", {31'd0, led}, 32'd1);
    @(negedge sysclk);
    check("blink edge8 led", {31'd0, led}, 32'd0);

    cnt = 0; prev = led;
    for (int i = 0; i < 30; i++) begin
      @(negedge sysclk);
      if (led !== prev) cnt++;
      prev = led;
    end
    check("blink transitions in 30", cnt, 32'd10);

    bus_wr(A_STATUS, 32'h0, 4'h0);
    repeat (29) @(negedge sysclk);
    bus_rd(A_STATUS, "blink STATUS", d);
    check("blink TOGGLES after 30", {16'd0, d[15:0]}, 32'd5);

    bus_wr(A_PERIOD, 32'd0, 4'hF);
    repeat (2) @(negedge sysclk);
    cnt = 0; prev = led;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      if (led !== prev) cnt++;
      prev = led;
    end
    check("blink frozen PERIOD=0", cnt, 32'd0);

    // 4. PWM
    bus_wr(A_DUTY, 32'd64, 4'h1);
    bus_wr(A_CTRL, 32'h5, 4'hF);
    repeat (3) @(negedge sysclk);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge sysclk);
      if (led === 1'b1) cnt++;
    end
    check("pwm duty64 highs", cnt, 32'd64);

    bus_wr(A_DUTY, 32'd0, 4'h1);
    repeat (2) @(negedge sysclk);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge sysclk);
      if (led === 1'b1) cnt++;
    end
    check("pwm duty0 highs", cnt, 32'd0);

    // 5. Bus corners
    bus_wr(A_PERIOD, 32'hAABB_CCDD, 4'b0010);
    rd_chk(A_PERIOD, "strobed PERIOD", 32'h0000_CC00);

    @(negedge sysclk);
    addr = A_DUTY; wdata = 32'h5A; wstrb = 4'hF; wen = 1'b1; ren = 1'b1;
    @(negedge sysclk);
    wen = 1'b0; ren = 1'b0; wstrb = 4'h0;
    check("rw same cycle rvalid", {31'd0, rvalid}, 32'd1);
    check("rw same cycle old DUTY", rdata, 32'h0);
    rd_chk(A_DUTY, "DUTY after rw", 32'h5A);

    @(negedge sysclk);
    addr = BASE - 12'h4; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wen = 1'b1; ren = 1'b1;
    @(negedge sysclk);
    wen = 1'b0; ren = 1'b0; wstrb = 4'h0;
    check("out of window rvalid", {31'd0, rvalid}, 32'd0);
    check("out of window rdata held", rdata, 32'h5A);
    rd_chk(A_CTRL,   "CTRL untouched",   32'h5);
    rd_chk(A_PERIOD, "PERIOD untouched", 32'h0000_CC00);
    rd_chk(A_DUTY,   "DUTY untouched",   32'h5A);

    // 6. Asynchronous reset mid-blink
    bus_wr(A_PERIOD, 32'd2, 4'hF);
    bus_wr(A_CTRL, 32'h3, 4'hF);
    k = 0;
    while (led !== 1'b1 && k < 20) begin
      @(negedge sysclk);
      k++;
    end
    check("blink high before reset", {31'd0, led}, 32'd1);
    #2 rst = 1'b1;
    #1 check("async reset led", {31'd0, led}, 32'd0);
    @(negedge sysclk);
    @(negedge sysclk);
    rst = 1'b0;
    rd_chk(A_CTRL,   "post-reset CTRL",   32'h0);
    rd_chk(A_PERIOD, "post-reset PERIOD", 32'h0);
    rd_chk(A_DUTY,   "post-reset DUTY",   32'h0);
    rd_chk(A_STATUS, "post-reset STATUS", 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
